// File: rtl/reg_ctx_pkg.sv
// Shared types and constants for the register context save/restore sequencer.
package reg_ctx_pkg;

    localparam int   ADDR_W       = 32;
    localparam int   WORD_BYTES   = 4;
    localparam logic MODE_SAVE    = 1'b0;
    localparam logic MODE_RESTORE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SAVE_REQ    = 3'd1,
        ST_RESTORE_REQ = 3'd2,
        ST_RESTORE_WR  = 3'd3,
        ST_FINISH      = 3'd4
    } state_t;

endpackage

// File: rtl/reg_context_engine.sv
// Moves the integer register file to/from a memory context area, one word per
// single-outstanding memory request, stalling the core (BUSY) while it runs.
module reg_context_engine
    import reg_ctx_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic                  MODE,
    input  logic [ADDR_W-1:0]     BASE_ADDR,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [REG_ADDR_W-1:0] RF_RADDR,
    input  logic [DATA_W-1:0]     RF_RDATA,
    output logic [REG_ADDR_W-1:0] RF_WADDR,
    output logic [DATA_W-1:0]     RF_WDATA,
    output logic                  RF_WRITE,
    output logic                  MEM_REQ,
    output logic                  MEM_WE,
    output logic [ADDR_W-1:0]     MEM_ADDR,
    output logic [DATA_W-1:0]     MEM_WDATA,
    input  logic                  MEM_ACK,
    input  logic [DATA_W-1:0]     MEM_RDATA
);

    localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0]     WORD_MASK = ~ADDR_W'(WORD_BYTES - 1);

    state_t                state;
    logic [REG_ADDR_W-1:0] idx;
    logic [ADDR_W-1:0]     base;
    logic [DATA_W-1:0]     rdata_q;
    logic                  last;

    assign last = (idx == LAST_IDX);

    // MODE needs no register of its own: the state chosen at START encodes it.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= ST_IDLE;
            idx     <= '0;
            base    <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        base  <= BASE_ADDR & WORD_MASK;
                        idx   <= '0;
                        state <= (MODE == MODE_RESTORE) ? ST_RESTORE_REQ : ST_SAVE_REQ;
                    end
                end
                ST_SAVE_REQ: begin
                    if (MEM_ACK) begin
                        if (last) state <= ST_FINISH;
                        else      idx   <= idx + 1'b1;
                    end
                end
                ST_RESTORE_REQ: begin
                    if (MEM_ACK) begin
                        rdata_q <= MEM_RDATA;
                        state   <= ST_RESTORE_WR;
                    end
                end
                ST_RESTORE_WR: begin
                    if (last) begin
                        state <= ST_FINISH;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_RESTORE_REQ;
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        BUSY      = (state != ST_IDLE);
        DONE      = (state == ST_FINISH);
        RF_RADDR  = '0;
        RF_WADDR  = '0;
        RF_WDATA  = '0;
        RF_WRITE  = 1'b0;
        MEM_REQ   = 1'b0;
        MEM_WE    = 1'b0;
        MEM_ADDR  = '0;
        MEM_WDATA = '0;
        case (state)
            ST_SAVE_REQ: begin
                RF_RADDR  = idx;
                MEM_REQ   = 1'b1;
                MEM_WE    = 1'b1;
                MEM_ADDR  = base + ADDR_W'(idx) * ADDR_W'(WORD_BYTES);
                MEM_WDATA = RF_RDATA;
            end
            ST_RESTORE_REQ: begin
                MEM_REQ  = 1'b1;
                MEM_ADDR = base + ADDR_W'(idx) * ADDR_W'(WORD_BYTES);
            end
            ST_RESTORE_WR: begin
                RF_WRITE = 1'b1;
                RF_WADDR = idx;
                RF_WDATA = rdata_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_context_engine.sv
// Directed bench for reg_context_engine with a behavioural register file and
// a memory responder whose wait-state policy each test selects.
module tb_reg_context_engine;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic        MODE = 1'b0;
    logic [31:0] BASE_ADDR = '0;
    logic        BUSY, DONE, RF_WRITE, MEM_REQ, MEM_WE;
    logic [4:0]  RF_RADDR, RF_WADDR;
    logic [31:0] RF_RDATA, RF_WDATA, MEM_ADDR, MEM_WDATA;
    logic        MEM_ACK = 1'b0;
    logic [31:0] MEM_RDATA = '0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] rf [32];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    int wait_mode = 0;   // 0 zero-wait, 1 random 0..3, 2 five waits on 0x201C
    int done_cnt = 0, rf_cnt = 0, rf_double = 0;
    bit prev_wr = 0, pend = 0;
    int wcnt = 0;

    reg_context_engine dut (
        .CLK(CLK), .RESET(RESET), .START(START), .MODE(MODE), .BASE_ADDR(BASE_ADDR),
        .BUSY(BUSY), .DONE(DONE), .RF_RADDR(RF_RADDR), .RF_RDATA(RF_RDATA),
        .RF_WADDR(RF_WADDR), .RF_WDATA(RF_WDATA), .RF_WRITE(RF_WRITE),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    assign RF_RDATA = rf[RF_RADDR];

    // Register file commits on the falling edge; also tracks pulse shapes.
    always @(negedge CLK) begin
        if (RF_WRITE) begin
            rf[RF_WADDR] = RF_WDATA;
            rf_cnt++;
            if (prev_wr) rf_double++;
        end
        prev_wr = RF_WRITE;
        if (DONE) done_cnt++;
    end

    // Memory responder: decides ACK for the current cycle at the falling edge.
    always @(negedge CLK) begin
        if (RESET || !MEM_REQ) begin
            pend    = 0;
            MEM_ACK = 1'b0;
        end else begin
            if (!pend) begin
                pend = 1;
                case (wait_mode)
                    1:       wcnt = int'($urandom_range(0, 3));
                    2:       wcnt = (MEM_ADDR == 32'h0000_201C) ? 5 : 0;
                    default: wcnt = 0;
                endcase
            end
            if (wcnt == 0) begin
                MEM_ACK = 1'b1;
                if (MEM_WE) begin
                    mem[MEM_ADDR] = MEM_WDATA;
                    wr_addr.push_back(MEM_ADDR);
                    wr_data.push_back(MEM_WDATA);
                    MEM_RDATA = '0;
                end else begin
                    MEM_RDATA = mem.exists(MEM_ADDR) ? mem[MEM_ADDR] : 32'hDEAD_BEEF;
                end
                pend = 0;
            end else begin
                wcnt--;
                MEM_ACK = 1'b0;
            end
        end
    end

    // Pulses START in cycle 0 and counts cycles until DONE is seen. With
    // stutter, START stays high (with flipped MODE) through BUSY and FINISH.
    task automatic run_xfer(input logic mode, input logic [31:0] base,
                            input bit stutter, output int cyc);
        @(negedge CLK);
        MODE = mode; BASE_ADDR = base; START = 1'b1;
        cyc = 0;
        forever begin
            @(negedge CLK);
            cyc++;
            START = stutter; MODE = ~mode; BASE_ADDR = 32'h0;
            if (DONE || cyc > 400) break;
        end
    endtask

    task automatic check_idle_after(input string tag);
        @(negedge CLK);
        n_cmp++;
        if (BUSY !== 1'b0 || MEM_REQ !== 1'b0) begin
            n_bad++;
            $display("FAIL %s idle1: busy=%b req=%b expected 0 0", tag, BUSY, MEM_REQ);
        end
        START = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (BUSY !== 1'b0) begin
            n_bad++;
            $display("FAIL %s idle2: busy=%b expected 0", tag, BUSY);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        n_cmp++;
        if ({BUSY, DONE, MEM_REQ, MEM_WE, RF_WRITE, MEM_ADDR, MEM_WDATA,
             RF_RADDR, RF_WADDR, RF_WDATA} !== '0) begin
            n_bad++;
            $display("FAIL %s: busy=%b done=%b req=%b we=%b rfw=%b addr=%h wd=%h ra=%h wa=%h rwd=%h expected all 0",
                     tag, BUSY, DONE, MEM_REQ, MEM_WE, RF_WRITE, MEM_ADDR, MEM_WDATA,
                     RF_RADDR, RF_WADDR, RF_WDATA);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge CLK);
        check_outputs_zero("reset_values");
        RESET = 1'b0;
        @(negedge CLK);
        check_outputs_zero("idle_after_reset");
    endtask

    task automatic test_save;
        int cyc, d0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        wait_mode = 0; wr_addr.delete(); wr_data.delete(); d0 = done_cnt;
        run_xfer(1'b0, 32'h2000, 1'b1, cyc);
        n_cmp++;
        if (cyc !== 33) begin
            n_bad++; $display("FAIL save_latency: got %0d expected 33", cyc);
        end
        n_cmp++;
        if (wr_addr.size() !== 32) begin
            n_bad++; $display("FAIL save_count: got %0d expected 32", wr_addr.size());
        end
        for (int i = 0; i < 32 && i < wr_addr.size(); i++) begin
            n_cmp++;
            if (wr_addr[i] !== 32'h2000 + 4 * i || wr_data[i] !== 32'h1000 + i) begin
                n_bad++;
                $display("FAIL save_word%0d: addr=%h data=%h expected %h %h",
                         i, wr_addr[i], wr_data[i], 32'h2000 + 4 * i, 32'h1000 + i);
            end
        end
        check_idle_after("save");
        n_cmp++;
        if (done_cnt - d0 !== 1) begin
            n_bad++; $display("FAIL save_done_count: got %0d expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_restore(input int wmode);
        int cyc, d0;
        for (int i = 0; i < 32; i++) begin
            mem[32'h4000 + 4 * i] = ~(32'(i));
            rf[i] = 32'h0;
        end
        wait_mode = wmode; rf_cnt = 0; rf_double = 0; d0 = done_cnt;
        run_xfer(1'b1, 32'h4000, 1'b0, cyc);
        n_cmp++;
        if ((wmode == 0 && cyc !== 65) || cyc < 65 || cyc > 65 + 32 * 3) begin
            n_bad++; $display("FAIL restore_latency(w%0d): got %0d expected 65..161", wmode, cyc);
        end
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (rf[i] !== ~(32'(i))) begin
                n_bad++; $display("FAIL restore_reg%0d: got %h expected %h", i, rf[i], ~(32'(i)));
            end
        end
        n_cmp++;
        if (rf_cnt !== 32 || rf_double !== 0) begin
            n_bad++; $display("FAIL restore_pulses: writes=%0d back_to_back=%0d expected 32 0", rf_cnt, rf_double);
        end
        check_idle_after("restore");
        n_cmp++;
        if (done_cnt - d0 !== 1) begin
            n_bad++; $display("FAIL restore_done_count: got %0d expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_stability;
        int cyc;
        bit seen;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        wait_mode = 2; seen = 0;
        @(negedge CLK);
        MODE = 1'b0; BASE_ADDR = 32'h2000; START = 1'b1;
        cyc = 0;
        while (cyc < 400) begin
            @(negedge CLK);
            cyc++;
            START = 1'b0;
            if (DONE) break;
            if (!seen && MEM_REQ && MEM_ADDR == 32'h201C) begin
                seen = 1;
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) begin @(negedge CLK); cyc++; end
                    n_cmp++;
                    if (MEM_ADDR !== 32'h201C || MEM_WDATA !== 32'h1007 ||
                        MEM_WE !== 1'b1 || RF_RADDR !== 5'd7) begin
                        n_bad++;
                        $display("FAIL hold_cycle%0d: addr=%h wd=%h we=%b ra=%0d expected 201c 1007 1 7",
                                 k, MEM_ADDR, MEM_WDATA, MEM_WE, RF_RADDR);
                    end
                end
            end
        end
        n_cmp++;
        if (seen !== 1'b1 || cyc !== 38) begin
            n_bad++; $display("FAIL hold_latency: seen=%b cycles=%0d expected 1 38", seen, cyc);
        end
        check_idle_after("hold");
    endtask

    task automatic test_addr_boundaries;
        int cyc;
        wait_mode = 0; wr_addr.delete(); wr_data.delete();
        run_xfer(1'b0, 32'h2003, 1'b0, cyc);
        n_cmp++;
        if (wr_addr.size() < 2 || wr_addr[0] !== 32'h2000 || wr_addr[1] !== 32'h2004) begin
            n_bad++;
            $display("FAIL base_align: size=%0d first=%h expected 2000 2004", wr_addr.size(),
                     wr_addr.size() > 0 ? wr_addr[0] : 32'hx);
        end
        check_idle_after("align");
        wr_addr.delete(); wr_data.delete();
        run_xfer(1'b0, 32'hFFFF_FFF8, 1'b0, cyc);
        n_cmp++;
        if (wr_addr.size() !== 32 || wr_addr[0] !== 32'hFFFF_FFF8 || wr_addr[1] !== 32'hFFFF_FFFC ||
            wr_addr[2] !== 32'h0 || wr_addr[31] !== 32'h74) begin
            n_bad++;
            $display("FAIL addr_wrap: size=%0d a0=%h a1=%h a2=%h a31=%h expected fffffff8 fffffffc 0 74",
                     wr_addr.size(), wr_addr[0], wr_addr[1], wr_addr[2], wr_addr[31]);
        end
        check_idle_after("wrap");
    endtask

    task automatic test_reset_mid_restore;
        int cyc, d0;
        bit found;
        for (int i = 0; i < 32; i++) begin
            mem[32'h6000 + 4 * i] = 32'h5A00_0000 + i;
            rf[i] = 32'hA5A5_0000 + i;
        end
        wait_mode = 0; d0 = done_cnt; found = 0;
        @(negedge CLK);
        MODE = 1'b1; BASE_ADDR = 32'h6000; START = 1'b1;
        for (cyc = 0; cyc < 200 && !found; cyc++) begin
            @(negedge CLK);
            START = 1'b0;
            if (MEM_REQ && !MEM_WE && MEM_ADDR == 32'h6028) found = 1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++; $display("FAIL reset_reach_idx10: request for 6028 seen=%b expected 1", found);
        end
        RESET = 1'b1;
        #1;
        check_outputs_zero("reset_immediate");
        @(negedge CLK);
        RESET = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            n_cmp++;
            if (MEM_REQ !== 1'b0 || BUSY !== 1'b0 || RF_WRITE !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_quiet%0d: req=%b busy=%b rfw=%b expected 0 0 0", k, MEM_REQ, BUSY, RF_WRITE);
            end
        end
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (rf[i] !== ((i < 10) ? 32'h5A00_0000 + i : 32'hA5A5_0000 + i)) begin
                n_bad++;
                $display("FAIL reset_reg%0d: got %h expected %h", i, rf[i],
                         (i < 10) ? 32'h5A00_0000 + i : 32'hA5A5_0000 + i);
            end
        end
        n_cmp++;
        if (done_cnt !== d0) begin
            n_bad++; $display("FAIL reset_no_done: done pulses=%0d expected 0", done_cnt - d0);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        test_reset();
        test_save();
        test_restore(0);
        test_restore(1);
        test_stability();
        test_addr_boundaries();
        test_reset_mid_restore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_context_engine.md
# reg_context_engine

Sequencer that moves the full contents of the 32 x 32-bit integer register file to and from a per-process context area in memory during an OS-initiated context switch. In SAVE mode it reads every register through a register-file read port and writes it to memory; in RESTORE mode it reads memory and drives the register-file write port. It sits beside the register file in the core, owns the core's context-switch stall (BUSY), and talks to the data-memory/cache side through a single-outstanding request/acknowledge port.

## Interface
- NUM_REGS, 32, registers transferred (indices 0..NUM_REGS-1, register 0 included)
- REG_ADDR_W, 5, register index width
- DATA_W, 32, register/memory word width
- Clock/reset: one clock; reset is asynchronous and active-high (CLK, RESET).
- CLK  in  1  clock; all state changes on rising edge
- RESET  in  1  asynchronous, active-high reset
- START  in  1  begin a transfer; sampled only in IDLE
- MODE  in  1  0 = SAVE (regfile -> memory), 1 = RESTORE (memory -> regfile); latched with START
- BASE_ADDR  in  32  context-area byte address; latched with START, bits [1:0] forced to 0
- BUSY  out  1  high from the cycle after START until DONE inclusive
- DONE  out  1  one-cycle completion pulse
- RF_RADDR  out  REG_ADDR_W  register-file read address
- RF_RDATA  in  DATA_W  register-file combinational read data
- RF_WADDR  out  REG_ADDR_W  register-file write address
- RF_WDATA  out  DATA_W  register-file write data
- RF_WRITE  out  1  register-file write enable
- MEM_REQ  out  1  memory request valid
- MEM_WE  out  1  1 = write, 0 = read
- MEM_ADDR  out  32  byte address = latched base + 4*index, mod 2^32
- MEM_WDATA  out  DATA_W  write data
- MEM_ACK  in  1  request accepted/completed this cycle
- MEM_RDATA  in  DATA_W  read data, valid when MEM_ACK is high on a read

## Operation
- States: IDLE, SAVE_REQ, RESTORE_REQ, RESTORE_WR, FINISH. Index counter idx, 0..NUM_REGS-1.
- IDLE: START=1 latches MODE/BASE_ADDR, idx<=0, next SAVE_REQ or RESTORE_REQ. START outside IDLE ignored.
- SAVE_REQ: RF_RADDR=idx; MEM_REQ=1, MEM_WE=1, MEM_ADDR=base+4*idx, MEM_WDATA=RF_RDATA. Held stable until MEM_ACK. On ACK: if idx==NUM_REGS-1 -> FINISH else idx++ (stay).
- RESTORE_REQ: MEM_REQ=1, MEM_WE=0, MEM_ADDR=base+4*idx. On ACK capture MEM_RDATA into data register -> RESTORE_WR.
- RESTORE_WR: RF_WRITE=1, RF_WADDR=idx, RF_WDATA=captured data for exactly one cycle (register file commits on that cycle's falling edge). Then FINISH if last index, else idx++ -> RESTORE_REQ.
- FINISH: DONE=1, BUSY=1, -> IDLE.
- Outputs outside their active state: MEM_REQ, MEM_WE, RF_WRITE, DONE = 0; address/data outputs 0.
- MEM_ACK without MEM_REQ is ignored.

## Timing
- Reset values: BUSY=0, DONE=0, MEM_REQ=0, MEM_WE=0, RF_WRITE=0, all address/data outputs 0, state IDLE, idx 0.
- Reset mid-transfer: immediate return to IDLE, no DONE; memory/regfile contents already written stay written, nothing further issued.
- ACK may arrive in the same cycle as REQ (zero wait) or any later cycle; one request outstanding max.
- Latency with zero-wait memory: SAVE, DONE in cycle NUM_REGS+1 after the START cycle (33); RESTORE, cycle 2*NUM_REGS+1 (65). Each wait cycle adds one.
- START asserted in the FINISH cycle is ignored; accepted from the following IDLE cycle.
- Address wrap: base 0xFFFF_FFF8 gives addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, ...

## Structure
- Package reg_ctx_pkg: state enum, MODE_SAVE=0 / MODE_RESTORE=1, WORD_BYTES=4.
- Single module; no sub-module (counter and FSM are small and tightly coupled).

## Test plan
- SAVE, zero-wait: regfile x_i = 0x1000+i, BASE=0x2000, START -> 32 writes, addr 0x2000+4i, data 0x1000+i, DONE in cycle 33, BUSY cleared after.
- RESTORE, random 0-3 wait cycles: memory word i = ~i, BASE=0x4000 -> each register i reads ~i, RF_WRITE exactly 32 single-cycle pulses, DONE once.
- Request stability: SAVE with ACK held low 5 cycles on idx 7 -> MEM_ADDR/MEM_WDATA/MEM_WE constant, idx not advanced.
- RESET asserted on idx 10 of RESTORE -> outputs to reset values at once, registers 0..9 restored, 10..31 unchanged, no DONE.
- START pulses while BUSY and in FINISH cycle -> ignored; BASE=0x2003 -> first address 0x2000; BASE=0xFFFF_FFF8 -> third address 0x0000_0000.
